// File: rtl/mem_port_arbiter.sv
// Multi-channel memory-port controller: arbitrates byte/half/word requests from NUM_CH
// clients and serialises them onto the core's 8-bit RAM/IO bus.
module mem_port_arbiter #(
    parameter int unsigned       NUM_CH     = 3,
    parameter int unsigned       ARB_MODE   = 1,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = 3'b011
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH-1:0]    we,
    input  logic [2*NUM_CH-1:0]  size,
    input  logic [32*NUM_CH-1:0] addr,
    input  logic [32*NUM_CH-1:0] wdata,
    output logic [NUM_CH-1:0]    done,
    output logic [31:0]          rdata,
    output logic                 busy,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr,
    input  logic                 io_buffer_full
);

    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic          we_q, we_d;
    logic [2:0]    n_q, n_d;
    logic [31:0]   base_q, base_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    iss_q, iss_d;
    logic [2:0]    cap_q, cap_d;
    logic          pend_q, pend_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_a_q, mem_a_d;
    logic [7:0]    mem_dout_q, mem_dout_d;
    logic          mem_wr_q, mem_wr_d;
    logic [CW-1:0] rr_q, rr_d;

    logic [NUM_CH-1:0] elig;
    logic              grant_vld;
    logic [CW-1:0]     grant_ch;
    logic [1:0]        g_size;
    logic [2:0]        cap_nx;
    logic              io_byte;
    logic              wr_blocked;

    assign io_byte    = (mem_a_q[17:16] == 2'b11);
    assign wr_blocked = io_byte & io_buffer_full;

    // Flushable requests are masked off while clear is high.
    assign elig = req & ~(clear ? FLUSH_MASK : '0);

    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        // Descending scan so the nearest eligible channel to the start point wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = 32'(k);
            if (ARB_MODE != 0) idx = idx + 32'(rr_q);
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (elig[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CW'(idx);
            end
        end
    end

    assign g_size = size[2*grant_ch +: 2];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            we_q       <= 1'b0;
            n_q        <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            iss_q      <= '0;
            cap_q      <= '0;
            pend_q     <= 1'b0;
            rdata_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            we_q       <= we_d;
            n_q        <= n_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            pend_q     <= pend_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            rr_q       <= rr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        we_d       = we_q;
        n_d        = n_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        pend_d     = pend_q;
        rdata_d    = rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        rr_d       = rr_q;
        cap_nx     = cap_q;

        if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        ch_d    = grant_ch;
                        we_d    = we[grant_ch];
                        n_d     = (g_size == 2'd0) ? 3'd1 : (g_size == 2'd1) ? 3'd2 : 3'd4;
                        base_d  = addr[32*grant_ch +: 32];
                        wdata_d = wdata[32*grant_ch +: 32];
                        iss_d   = '0;
                        cap_d   = '0;
                        pend_d  = 1'b0;
                        rdata_d = '0;
                        mem_a_d = addr[32*grant_ch +: 32];
                        if (we[grant_ch]) begin
                            state_d    = StWr;
                            mem_dout_d = wdata[32*grant_ch +: 8];
                            mem_wr_d   = 1'b1;
                        end else begin
                            state_d = StRd;
                        end
                    end
                end
                StRd: begin
                    if (clear && FLUSH_MASK[ch_q]) begin
                        state_d = StIdle;
                        mem_a_d = '0;
                        pend_d  = 1'b0;
                    end else begin
                        // Data for the byte issued last cycle is on mem_din now.
                        if (pend_q) begin
                            rdata_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                            cap_nx = cap_q + 3'd1;
                        end
                        cap_d = cap_nx;
                        if (cap_nx == n_q) begin
                            state_d = StDone;
                            mem_a_d = '0;
                            pend_d  = 1'b0;
                        end else if (iss_q < n_q) begin
                            pend_d = 1'b1;
                            iss_d  = iss_q + 3'd1;
                            if (iss_d < n_q) mem_a_d = base_q + 32'(iss_d);
                        end else begin
                            pend_d = 1'b0;
                        end
                    end
                end
                StWr: begin
                    if (!wr_blocked) begin
                        if (iss_q + 3'd1 == n_q) begin
                            state_d    = StDone;
                            mem_wr_d   = 1'b0;
                            mem_a_d    = '0;
                            mem_dout_d = '0;
                        end else begin
                            iss_d      = iss_q + 3'd1;
                            mem_a_d    = base_q + 32'(iss_d);
                            mem_dout_d = wdata_q[{iss_d[1:0], 3'b000} +: 8];
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    if (ARB_MODE != 0) begin
                        rr_d = (32'(ch_q) == NUM_CH - 1) ? '0 : ch_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q == StRd) begin
            // A stalled cycle loses any byte in flight: restart from the first uncaptured byte.
            iss_d   = cap_q;
            pend_d  = 1'b0;
            mem_a_d = base_q + 32'(cap_q);
        end
    end

    always_comb begin
        done = '0;
        if (state_q == StDone && rdy_in && !(clear && FLUSH_MASK[ch_q] && !we_q)) begin
            done[ch_q] = 1'b1;
        end
    end

    assign rdata    = rdata_q;
    assign busy     = (state_q != StIdle);
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q & rdy_in & ~wr_blocked;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin instance plus a fixed-priority instance
// fed the same stimulus, with a small synchronous RAM model on the round-robin bus.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, clear, io_buffer_full;
    logic [2:0]  req, we;
    logic [5:0]  size;
    logic [95:0] addr, wdata;
    logic [7:0]  mem_din;

    logic [2:0]  done, done_fp;
    logic [31:0] rdata, rdata_fp, mem_a, mem_a_fp;
    logic        busy, busy_fp, mem_wr, mem_wr_fp;
    logic [7:0]  mem_dout, mem_dout_fp;

    logic [7:0]  ram [0:4095];

    int n_chk  = 0;
    int n_pass = 0;

    mem_port_arbiter #(.NUM_CH(3), .ARB_MODE(1), .FLUSH_MASK(3'b011)) u_dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    mem_port_arbiter #(.NUM_CH(3), .ARB_MODE(0), .FLUSH_MASK(3'b011)) u_dut_fp (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
        .done(done_fp), .rdata(rdata_fp), .busy(busy_fp),
        .mem_din(mem_din), .mem_dout(mem_dout_fp), .mem_a(mem_a_fp), .mem_wr(mem_wr_fp),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_ch(input int ch, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        we[ch]            = w;
        size[2*ch +: 2]   = sz;
        addr[32*ch +: 32] = a;
        wdata[32*ch +: 32] = d;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done != 3'b000) break;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  exp_g [4];
        logic [31:0] exp_d [4];
        exp_g = '{3'd1, 3'd2, 3'd4, 3'd1};
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h11};

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11;
        ram[12'h101] = 8'h22;
        ram[12'h102] = 8'h33;
        ram[12'h103] = 8'h44;
        mem_din = 8'h00;

        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        req = '0; we = '0; size = '0; addr = '0; wdata = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_in = 1'b1;
        tick();

        // Word read, ch1, 0x100
        set_ch(1, 1'b0, 2'd2, 32'h100, 32'h0);
        req = 3'b010;
        tick();
        chk("rd_a0", mem_a, 32'h100);
        chk("rd_wr0", 32'(mem_wr), 32'h0);
        chk("rd_busy", 32'(busy), 32'h1);
        tick(); chk("rd_a1", mem_a, 32'h101);
        tick(); chk("rd_a2", mem_a, 32'h102);
        tick(); chk("rd_a3", mem_a, 32'h103);
        tick(); chk("rd_not_done_t5", 32'(done), 32'h0);
        tick();
        chk("rd_done_t6", 32'(done), 32'h2);
        chk("rd_rdata", rdata, 32'h44332211);
        req = 3'b000;
        tick();

        // Half write to IO, ch2, UART full for two cycles
        set_ch(2, 1'b1, 2'd1, 32'h30000, 32'h0000ABCD);
        io_buffer_full = 1'b1;
        req = 3'b100;
        tick();
        chk("io_wr_blk1", 32'(mem_wr), 32'h0);
        chk("io_a0", mem_a, 32'h30000);
        chk("io_dout0", 32'(mem_dout), 32'hCD);
        tick();
        chk("io_wr_blk2", 32'(mem_wr), 32'h0);
        tick();
        io_buffer_full = 1'b0;
        #1;
        chk("io_wr_b0", 32'(mem_wr), 32'h1);
        chk("io_dout_b0", 32'(mem_dout), 32'hCD);
        tick();
        chk("io_wr_b1", 32'(mem_wr), 32'h1);
        chk("io_a1", mem_a, 32'h30001);
        chk("io_dout_b1", 32'(mem_dout), 32'hAB);
        tick();
        chk("io_done_t5", 32'(done), 32'h4);
        chk("io_wr_idle", 32'(mem_wr), 32'h0);
        req = 3'b000;
        tick();

        // All three channels requesting: round-robin vs fixed priority
        set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0);
        set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0);
        set_ch(2, 1'b0, 2'd0, 32'h102, 32'h0);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_done();
            chk("rr_grant", 32'(done), 32'(exp_g[k]));
            chk("rr_rdata", rdata, exp_d[k]);
            chk("fp_grant", 32'(done_fp), 32'h1);
            if (k == 3) req = 3'b000;
            tick();
        end

        // Flush of a speculative ch0 word read in t+3
        set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
        req = 3'b001;
        tick(); chk("fl_wr_t1", 32'(mem_wr), 32'h0);
        tick(); chk("fl_wr_t2", 32'(mem_wr), 32'h0);
        tick();
        clear = 1'b1;
        req = 3'b000;
        chk("fl_busy_t3", 32'(busy), 32'h1);
        tick();
        clear = 1'b0;
        chk("fl_idle_t4", 32'(busy), 32'h0);
        chk("fl_a_t4", mem_a, 32'h0);
        chk("fl_nodone_t4", 32'(done), 32'h0);
        tick();
        chk("fl_nodone_t5", 32'(done), 32'h0);
        chk("fl_nodone_fp", 32'(done_fp), 32'h0);

        // Clear during a ch1 word write does not abort it
        set_ch(1, 1'b1, 2'd2, 32'h200, 32'hDEADBEEF);
        req = 3'b010;
        tick();
        chk("cw_a0", mem_a, 32'h200);
        chk("cw_d0", 32'(mem_dout), 32'hEF);
        chk("cw_wr0", 32'(mem_wr), 32'h1);
        tick();
        clear = 1'b1;
        chk("cw_d1", 32'(mem_dout), 32'hBE);
        tick();
        clear = 1'b0;
        chk("cw_d2", 32'(mem_dout), 32'hAD);
        tick();
        chk("cw_d3", 32'(mem_dout), 32'hDE);
        chk("cw_a3", mem_a, 32'h203);
        tick();
        chk("cw_done", 32'(done), 32'h2);
        req = 3'b000;
        tick();

        // Clear in the DONE cycle of a flushable read suppresses done
        set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0);
        req = 3'b001;
        tick(); tick(); tick();
        clear = 1'b1;
        req = 3'b000;
        #1;
        chk("cd_busy", 32'(busy), 32'h1);
        chk("cd_nodone", 32'(done), 32'h0);
        tick();
        clear = 1'b0;
        chk("cd_idle", 32'(busy), 32'h0);

        // rdy_in low in t+2 of a word read: re-issue from byte 0, done at t+8
        set_ch(1, 1'b0, 2'd2, 32'h100, 32'h0);
        req = 3'b010;
        tick(); chk("st_a_t1", mem_a, 32'h100);
        tick();
        rdy_in = 1'b0;
        #1;
        chk("st_a_t2", mem_a, 32'h101);
        tick();
        rdy_in = 1'b1;
        chk("st_a_t3", mem_a, 32'h100);
        tick(); chk("st_a_t4", mem_a, 32'h101);
        tick(); chk("st_a_t5", mem_a, 32'h102);
        tick(); chk("st_a_t6", mem_a, 32'h103);
        tick(); chk("st_nodone_t7", 32'(done), 32'h0);
        tick();
        chk("st_done_t8", 32'(done), 32'h2);
        chk("st_rdata", rdata, 32'h44332211);
        req = 3'b000;
        tick();

        // Asynchronous reset in the middle of a write
        set_ch(2, 1'b1, 2'd2, 32'h300, 32'h12345678);
        req = 3'b100;
        tick();
        chk("ar_wr_t1", 32'(mem_wr), 32'h1);
        chk("ar_d_t1", 32'(mem_dout), 32'h78);
        tick();
        rst_in = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_wr", 32'(mem_wr), 32'h0);
        chk("ar_a", mem_a, 32'h0);
        chk("ar_dout", 32'(mem_dout), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        req = 3'b000;
        tick();
        rst_in = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
